seg_scan_ctrl: RTL

Time-multiplexed scan controller for a multi-digit common-cathode 7-segment display. It shares one combinational BCD-to-segment decoder across `DIGITS` digit positions and drives the decoder's BCD input one digit per scan slot. It registers the returned segment pattern together with an active-low digit select. New display values are double-buffered and committed only at frame boundaries, so no frame ever shows a mix of old and new digits.

---
 rtl/seg_scan_ctrl.sv | 112 +++++++++++
 1 files changed

// File: rtl/seg_scan_ctrl.sv
// Scan controller for a multiplexed common-cathode 7-segment display. One shared
// BCD decoder is time-shared across the digits; new values commit only at frame wrap.

module seg_scan_digit (
  input  logic [3:0] nib,
  output logic       invalid,
  output logic       is_zero
);
  assign invalid = (nib > 4'd9);
  assign is_zero = (nib == 4'd0);
endmodule

module seg_scan_ctrl #(
  parameter int DIGITS    = 4,
  parameter int DIV       = 3000,
  parameter int BLANK_CYC = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic                  load,
  output logic                  ack,
  input  logic                  lzb_en,
  input  logic [DIGITS-1:0]     dp_mask,
  output logic [3:0]            dec_data,
  input  logic [8:0]            dec_seg,
  output logic [8:0]            seg,
  output logic [DIGITS-1:0]     dig_sel,
  output logic                  frame_start
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = $clog2(DIGITS);
  localparam logic [CW-1:0] CNT_MAX   = CW'(DIV - 1);
  localparam logic [IW-1:0] IDX_MAX   = IW'(DIGITS - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);

  logic [CW-1:0]            cnt;
  logic [IW-1:0]            idx;
  logic [DIGITS-1:0][3:0]   disp;
  logic [DIGITS-1:0][3:0]   stg;
  logic                     pending;
  logic                     slot_end;
  logic                     frame_end;
  logic [DIGITS-1:0]        invalid;
  logic [DIGITS-1:0]        nib_zero;
  logic [DIGITS-1:0]        zero_run;
  logic                     blank;
  logic                     unused_dec_hi;

  assign slot_end  = (cnt == CNT_MAX);
  assign frame_end = slot_end && (idx == IDX_MAX);

  // Slot prescaler and scan index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= frame_end ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Double buffer: a load always lands in stg; disp only changes at frame wrap,
  // taking the stg value from before any same-cycle load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp        <= '0;
      stg         <= '0;
      pending     <= 1'b0;
      ack         <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      ack         <= frame_end && pending;
      frame_start <= frame_end;
      if (frame_end && pending)
        disp <= stg;
      if (load) begin
        stg     <= bcd_in;
        pending <= 1'b1;
      end else if (frame_end) begin
        pending <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    seg_scan_digit u_cell (
      .nib     (disp[i]),
      .invalid (invalid[i]),
      .is_zero (nib_zero[i])
    );
    // Digit i and every more-significant digit are zero
    assign zero_run[i] = &nib_zero[DIGITS-1:i];
  end

  assign dec_data      = disp[idx];
  assign blank         = invalid[idx] || (lzb_en && (idx != '0) && zero_run[idx]);
  assign unused_dec_hi = ^dec_seg[8:7];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg     <= '0;
      dig_sel <= '1;
    end else begin
      seg     <= {1'b0, dp_mask[idx], blank ? 7'd0 : dec_seg[6:0]};
      dig_sel <= (cnt < BLANK_END) ? '1 : ~(DIGITS'(1) << idx);
    end
  end
endmodule
